// File: rtl/if_pkg.sv
// ============================================================================
//  Module      : if_pkg
//  Description : Shared defaults and halt encoding for the instruction prefetch
//                stage and its fetch queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_pkg;

    localparam int          c_NB_PC          = 32;
    localparam int          c_NB_INSTRUCTION = 32;
    localparam int          c_QUEUE_DEPTH    = 4;
    localparam int          c_PC_STEP        = 4;
    localparam logic [31:0] c_RESET_PC       = 32'h0000_0000;
    localparam logic [31:0] c_HALT_WORD      = 32'hFFFF_FFFF;

    // Occupancy needs one extra bit so a full queue is distinguishable from empty.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
//  Module      : fetch_queue
//  Description : Synchronous FIFO with single-cycle flush; head is read
//                combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = c_QUEUE_DEPTH,
    parameter int WIDTH = c_NB_INSTRUCTION + c_NB_PC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_flush,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [WIDTH-1:0]            i_data,
    output logic [WIDTH-1:0]            o_data,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Flush wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

`default_nettype wire

// File: rtl/if_prefetch_stage.sv
// ============================================================================
//  Module      : if_prefetch_stage
//  Description : Instruction prefetch stage: credit-limited memory reads into a
//                fetch queue, with jump/branch redirect and sticky halt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_prefetch_stage
    import if_pkg::*;
#(
    parameter int                          NB_PC          = c_NB_PC,
    parameter int                          NB_INSTRUCTION = c_NB_INSTRUCTION,
    parameter int                          QUEUE_DEPTH    = c_QUEUE_DEPTH,
    parameter int                          PC_STEP        = c_PC_STEP,
    parameter logic [NB_PC-1:0]            RESET_PC       = NB_PC'(c_RESET_PC),
    parameter logic [NB_INSTRUCTION-1:0]   HALT_WORD      = NB_INSTRUCTION'(c_HALT_WORD)
) (
    input  logic                                  i_clock,
    input  logic                                  i_reset_n,
    input  logic                                  i_enable,
    input  logic                                  i_branch,
    input  logic [NB_PC-1:0]                      i_branch_addr,
    input  logic                                  i_jump,
    input  logic [NB_PC-1:0]                      i_jump_address,
    output logic                                  o_imem_read_enable,
    output logic [NB_PC-1:0]                      o_imem_addr,
    input  logic [NB_INSTRUCTION-1:0]             i_imem_data,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic [NB_INSTRUCTION-1:0]             o_instruction,
    output logic [NB_PC-1:0]                      o_adder_result,
    output logic                                  o_halted,
    output logic [count_width(QUEUE_DEPTH)-1:0]   o_count
);

    localparam int               CW        = count_width(QUEUE_DEPTH);
    localparam int               EW        = NB_INSTRUCTION + NB_PC;
    localparam logic [NB_PC-1:0] c_pc_step = NB_PC'(PC_STEP);
    localparam logic [CW:0]      c_depth   = (CW+1)'(QUEUE_DEPTH);

    logic [NB_PC-1:0] r_fetch_pc;
    logic             r_inflight;
    logic [NB_PC-1:0] r_inflight_pc;
    logic             r_halted;

    logic             w_redirect;
    logic [NB_PC-1:0] w_target;
    logic [CW:0]      w_credit_used;
    logic             w_issue;
    logic             w_push;
    logic             w_halt_hit;
    logic             w_pop;
    logic [EW-1:0]    w_push_data;
    logic [EW-1:0]    w_head;
    logic [CW-1:0]    w_count;
    logic             w_empty;

    assign w_redirect    = i_jump | i_branch;
    assign w_target      = i_jump ? i_jump_address : i_branch_addr;
    assign w_credit_used = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};

    // Reset is folded in so the strobe drops the instant reset is asserted.
    assign w_issue = i_reset_n & i_enable & ~r_halted & ~w_redirect &
                     (w_credit_used < c_depth);

    // A redirect squashes the word returning this cycle.
    assign w_push      = r_inflight & ~w_redirect;
    assign w_halt_hit  = w_push & (i_imem_data == HALT_WORD);
    assign w_push_data = {i_imem_data, r_inflight_pc + c_pc_step};
    assign w_pop       = o_valid & i_ready;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_halted      <= 1'b0;
        end else begin
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_inflight <= 1'b0;
            end else if (w_halt_hit) begin
                // Drop any read issued alongside the halt word; the PC is left
                // pointing at that read's address.
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_fetch_pc    <= r_fetch_pc + c_pc_step;
                    r_inflight_pc <= r_fetch_pc;
                end
            end
            if (w_halt_hit) begin
                r_halted <= 1'b1;
            end
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (EW)
    ) u_fetch_queue (
        .clk     (i_clock),
        .rst_n   (i_reset_n),
        .i_flush (w_redirect),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign o_imem_read_enable = w_issue;
    assign o_imem_addr        = r_fetch_pc;
    assign o_valid            = ~w_empty;
    assign o_count            = w_count;
    assign o_halted           = r_halted;

    // Head storage is not reset, so mask it whenever the queue is empty.
    assign o_instruction  = o_valid ? w_head[EW-1 -: NB_INSTRUCTION] : '0;
    assign o_adder_result = o_valid ? w_head[NB_PC-1:0] : '0;

endmodule

`default_nettype wire

// File: tb/tb_if_prefetch_stage.sv
// ============================================================================
//  Module      : tb_if_prefetch_stage
//  Description : Self-checking bench for if_prefetch_stage with a program-order
//                reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_prefetch_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] imem_data = '0;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] adder;
    logic        halted;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    logic        halt_en = 1'b0;
    logic [31:0] halt_addr = '0;

    if_prefetch_stage dut (
        .i_clock            (clk),
        .i_reset_n          (rst_n),
        .i_enable           (enable),
        .i_branch           (branch),
        .i_branch_addr      (branch_addr),
        .i_jump             (jump),
        .i_jump_address     (jump_addr),
        .o_imem_read_enable (rd_en),
        .o_imem_addr        (rd_addr),
        .i_imem_data        (imem_data),
        .o_valid            (valid),
        .i_ready            (ready),
        .o_instruction      (instr),
        .o_adder_result     (adder),
        .o_halted           (halted),
        .o_count            (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (halt_en && a == halt_addr) return HALT;
        return a >> 2;
    endfunction

    // Memory: data for a strobe seen in one cycle is presented in the next.
    logic        pend_en;
    logic [31:0] pend_addr;
    always begin
        @(negedge clk);
        pend_en   = rd_en;
        pend_addr = rd_addr;
        @(posedge clk);
        #1;
        imem_data = pend_en ? memf(pend_addr) : (32'h0BAD_0000 | ($urandom & 32'hFFFF));
    end

    // Program-order model: deliveries and reads follow consecutive PCs from the
    // last reset/redirect target; nothing is delivered after the halt word.
    logic [31:0] exp_pc;
    logic [31:0] exp_rd;
    logic        exp_done;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc   = 32'h0;
            exp_rd   = 32'h0;
            exp_done = 1'b0;
        end else begin
            total++;
            if (valid !== (count != 0) || count > 3'd4) begin
                bad++;
                $display("FAIL mon_occupancy valid=%0b count=%0d", valid, count);
            end
            if (rd_en) begin
                total++;
                if (rd_addr !== exp_rd || exp_done || branch || jump) begin
                    bad++;
                    $display("FAIL mon_read addr=%h expected=%h done=%0b redirect=%0b",
                             rd_addr, exp_rd, exp_done, branch | jump);
                end
                exp_rd = exp_rd + 32'd4;
            end
            if (valid && ready) begin
                total++;
                if (exp_done || instr !== memf(exp_pc) || adder !== exp_pc + 32'd4) begin
                    bad++;
                    $display("FAIL mon_deliver instr=%h adder=%h expected instr=%h adder=%h done=%0b",
                             instr, adder, memf(exp_pc), exp_pc + 32'd4, exp_done);
                end
                if (memf(exp_pc) == HALT) exp_done = 1'b1;
                exp_pc = exp_pc + 32'd4;
            end
            if (jump) begin
                exp_pc = jump_addr;
                exp_rd = jump_addr;
            end else if (branch) begin
                exp_pc = branch_addr;
                exp_rd = branch_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        ready  = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total++;
        if (valid !== 1'b0 || rd_en !== 1'b0 || halted !== 1'b0 || count !== 3'd0) begin
            bad++;
            $display("FAIL reset_ctrl valid=%0b rd_en=%0b halted=%0b count=%0d required 0/0/0/0",
                     valid, rd_en, halted, count);
        end
        total++;
        if (instr !== 32'h0 || adder !== 32'h0 || rd_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_data instr=%h adder=%h addr=%h required all 0", instr, adder, rd_addr);
        end
        tick();
    endtask

    task automatic test_basic();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (c < 2) begin
                if (rd_en !== 1'b1 || rd_addr !== 32'(c * 4) || valid !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_c%0d rd_en=%0b addr=%h valid=%0b required 1/%h/0",
                             c, rd_en, rd_addr, valid, c * 4);
                end
            end else begin
                if (valid !== 1'b1 || instr !== 32'(c - 2) || adder !== 32'((c - 1) * 4)) begin
                    bad++;
                    $display("FAIL basic_c%0d valid=%0b instr=%h adder=%h required 1/%h/%h",
                             c, valid, instr, adder, c - 2, (c - 1) * 4);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int reads;
        ready     = 1'b0;
        jump      = 1'b1;
        jump_addr = 32'h40;
        @(negedge clk);
        total++;
        if (rd_en !== 1'b0) begin
            bad++;
            $display("FAIL stall_redirect_strobe rd_en=%0b required 0", rd_en);
        end
        tick();
        jump  = 1'b0;
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_en) reads++;
            tick();
        end
        @(negedge clk);
        total++;
        if (reads != 4 || count !== 3'd4 || rd_en !== 1'b0) begin
            bad++;
            $display("FAIL stall_fill reads=%0d count=%0d rd_en=%0b required 4/4/0", reads, count, rd_en);
        end
        tick();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (valid !== 1'b1 || instr !== 32'(16 + i)) begin
                bad++;
                $display("FAIL stall_resume_%0d valid=%0b instr=%h required 1/%h", i, valid, instr, 16 + i);
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        ready     = 1'b0;
        jump      = 1'b1;
        jump_addr = 32'h80;
        tick();
        jump = 1'b0;
        repeat (4) tick();
        branch      = 1'b1;
        branch_addr = 32'h100;
        jump        = 1'b1;
        jump_addr   = 32'h200;
        @(negedge clk);
        total++;
        if (count !== 3'd3 || rd_en !== 1'b0) begin
            bad++;
            $display("FAIL redir_pre count=%0d rd_en=%0b required 3/0", count, rd_en);
        end
        tick();
        branch = 1'b0;
        jump   = 1'b0;
        ready  = 1'b1;
        @(negedge clk);
        total++;
        if (count !== 3'd0 || valid !== 1'b0 || rd_en !== 1'b1 || rd_addr !== 32'h200) begin
            bad++;
            $display("FAIL redir_post count=%0d valid=%0b rd_en=%0b addr=%h required 0/0/1/200",
                     count, valid, rd_en, rd_addr);
        end
        tick();
        @(negedge clk);
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL redir_stale valid=%0b instr=%h required valid 0", valid, instr);
        end
        tick();
        @(negedge clk);
        total++;
        if (valid !== 1'b1 || instr !== 32'h80 || adder !== 32'h204) begin
            bad++;
            $display("FAIL redir_first valid=%0b instr=%h adder=%h required 1/80/204", valid, instr, adder);
        end
        repeat (6) tick();
    endtask

    task automatic test_wrap();
        ready     = 1'b1;
        jump      = 1'b1;
        jump_addr = 32'hFFFF_FFF8;
        tick();
        jump = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'hFFFF_FFF8 + 32'(i * 4);
            @(negedge clk);
            total++;
            if (rd_en !== 1'b1 || rd_addr !== a) begin
                bad++;
                $display("FAIL wrap_read_%0d rd_en=%0b addr=%h required 1/%h", i, rd_en, rd_addr, a);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (valid !== 1'b1 || instr !== 32'h3FFF_FFFF || adder !== 32'h0) begin
            bad++;
            $display("FAIL wrap_tag valid=%0b instr=%h adder=%h required 1/3fffffff/0", valid, instr, adder);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        ready     = 1'b0;
        jump      = 1'b1;
        jump_addr = 32'h20;
        tick();
        jump = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        total++;
        if (count !== 3'd3) begin
            bad++;
            $display("FAIL rstmid_pre count=%0d required 3", count);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (valid !== 1'b0 || count !== 3'd0 || rd_en !== 1'b0 || instr !== 32'h0 || adder !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_now valid=%0b count=%0d rd_en=%0b instr=%h adder=%h required all 0",
                     valid, count, rd_en, instr, adder);
        end
        tick();
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        total++;
        if (rd_en !== 1'b1 || rd_addr !== 32'h0) begin
            bad++;
            $display("FAIL rstmid_first_read rd_en=%0b addr=%h required 1/0", rd_en, rd_addr);
        end
        tick();
        tick();
        @(negedge clk);
        total++;
        if (valid !== 1'b1 || instr !== 32'h0 || adder !== 32'h4) begin
            bad++;
            $display("FAIL rstmid_first_deliver valid=%0b instr=%h adder=%h required 1/0/4", valid, instr, adder);
        end
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int r;
            r           = int'($urandom_range(0, 99));
            enable      = ($urandom_range(0, 9) < 8);
            ready       = ($urandom_range(0, 9) < 6);
            jump        = (r < 4);
            branch      = (r >= 2 && r < 7);
            jump_addr   = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            branch_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            tick();
        end
        jump   = 1'b0;
        branch = 1'b0;
        enable = 1'b0;
        ready  = 1'b1;
        repeat (8) tick();
        enable = 1'b1;
    endtask

    task automatic test_halt();
        bit seen;
        int reads_after;
        int deliv_after;
        seen        = 1'b0;
        reads_after = 0;
        deliv_after = 0;
        halt_en     = 1'b1;
        halt_addr   = 32'h10;
        enable      = 1'b1;
        ready       = 1'b1;
        jump        = 1'b1;
        jump_addr   = 32'h0;
        tick();
        jump = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (halted && rd_en) reads_after++;
            if (valid && seen) deliv_after++;
            if (valid && instr == HALT) begin
                seen = 1'b1;
                total++;
                if (adder !== 32'h14) begin
                    bad++;
                    $display("FAIL halt_tag adder=%h required 14", adder);
                end
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (!seen || halted !== 1'b1 || reads_after != 0 || deliv_after != 0) begin
            bad++;
            $display("FAIL halt_stop seen=%0b halted=%0b reads_after=%0d deliv_after=%0d required 1/1/0/0",
                     seen, halted, reads_after, deliv_after);
        end
        tick();
        jump      = 1'b1;
        jump_addr = 32'h40;
        tick();
        jump = 1'b0;
        @(negedge clk);
        total++;
        if (rd_addr !== 32'h40 || rd_en !== 1'b0 || halted !== 1'b1 || count !== 3'd0) begin
            bad++;
            $display("FAIL halt_redirect addr=%h rd_en=%0b halted=%0b count=%0d required 40/0/1/0",
                     rd_addr, rd_en, halted, count);
        end
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
